sweep_stim_gen: RTL and testbench



---
 rtl/sweep_stim_gen.sv | 127 ++++++++++++
 tb/tb_sweep_stim_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_stim_gen.sv
// Exhaustive / LFSR stimulus sweep with per-vector dwell and response signature.
// Define RESP_MISR_EN for a MISR signature; otherwise a last-response capture.
module sweep_stim_gen #(
   parameter int                STIM_W      = 6,
   parameter int                STEP_CYCLES = 10,
   parameter int                RESP_W      = 3,
   parameter logic [STIM_W-1:0] LFSR_TAPS   = 6'b110000,
   parameter logic [RESP_W-1:0] MISR_POLY   = 3'b011
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic [STIM_W-1:0] seed,
   input  logic [STIM_W:0]   vec_count,
   input  logic [RESP_W-1:0] resp,
   output logic [STIM_W-1:0] stim,
   output logic              stim_valid,
   output logic [STIM_W:0]   vec_idx,
   output logic              busy,
   output logic              done,
   output logic [RESP_W-1:0] signature
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DWELL  = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   localparam int CNT_W =
      (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [STIM_W:0]  N_FULL   = {1'b1, {STIM_W{1'b0}}};

   logic [1:0]                   r_state;
   logic                         r_mode;
   logic [STIM_W:0]              r_n;
   logic [CNT_W-1:0]             r_cnt;
   logic [STIM_W-1:0]            r_stim;
   logic [STIM_W:0]              r_idx;
   logic [$bits(MISR_POLY)-1:0]  r_sig;

   logic                         w_last;
   logic                         w_end;
   logic [STIM_W-1:0]            w_stim_nxt;
   logic [STIM_W-1:0]            w_seed;
   logic [RESP_W-1:0]            w_sig_nxt;

   assign w_last = (r_cnt == CNT_LAST);
   assign w_end  = (r_idx == r_n - 1'b1);
   assign w_seed = (seed == '0) ?
                   {{(STIM_W-1){1'b0}}, 1'b1} : seed;

   assign w_stim_nxt = r_mode ?
      {r_stim[STIM_W-2:0], ^(r_stim & LFSR_TAPS)} :
      r_stim + 1'b1;

`ifdef RESP_MISR_EN
   assign w_sig_nxt = {r_sig[RESP_W-2:0], 1'b0}
                    ^ (r_sig[RESP_W-1] ? MISR_POLY : '0)
                    ^ resp;
`else
   assign w_sig_nxt = resp;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_mode  <= 1'b0;
         r_n     <= '0;
         r_cnt   <= '0;
         r_stim  <= '0;
         r_idx   <= '0;
         r_sig   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !abort) begin
                  r_sig  <= '0;
                  r_mode <= mode;
                  r_cnt  <= '0;
                  r_idx  <= '0;
                  // Empty LFSR run: report completion without sweeping
                  if (mode && vec_count == '0) begin
                     r_state <= S_FINISH;
                  end else begin
                     r_state <= S_DWELL;
                     r_n     <= mode ? vec_count : N_FULL;
                     r_stim  <= mode ? w_seed : '0;
                  end
               end
            end
            S_DWELL: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  r_stim  <= '0;
                  r_idx   <= '0;
                  r_cnt   <= '0;
               end else if (w_last) begin
                  r_sig <= w_sig_nxt;
                  r_cnt <= '0;
                  if (w_end) begin
                     r_state <= S_FINISH;
                     r_stim  <= '0;
                     r_idx   <= '0;
                  end else begin
                     r_stim <= w_stim_nxt;
                     r_idx  <= r_idx + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign stim       = r_stim;
   assign vec_idx    = r_idx;
   assign busy       = (r_state == S_DWELL);
   assign stim_valid = (r_state == S_DWELL);
   assign done       = (r_state == S_FINISH);
   assign signature  = r_sig;

endmodule

// File: tb/tb_sweep_stim_gen.sv
// Directed bench for sweep_stim_gen: table of full runs plus
// hand sequences for abort, reset, start-while-busy and empty runs.
module tb_sweep_stim_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       mode;
   logic [5:0] seed;
   logic [6:0] vec_count;
   logic [2:0] resp;
   logic [5:0] stim;
   logic       stim_valid;
   logic [6:0] vec_idx;
   logic       busy;
   logic       done;
   logic [2:0] signature;

   int checks   = 0;
   int failures = 0;
   int seen[64];

   always #5 clk = ~clk;

   sweep_stim_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .seed       (seed),
      .vec_count  (vec_count),
      .resp       (resp),
      .stim       (stim),
      .stim_valid (stim_valid),
      .vec_idx    (vec_idx),
      .busy       (busy),
      .done       (done),
      .signature  (signature)
   );

   typedef struct {
      logic       m;
      logic [5:0] sd;
      logic [6:0] vc;
      logic [2:0] rsp;
      int         cyc;
      int         nv;
      logic [2:0] sig_misr;
      logic [2:0] sig_cap;
      logic [5:0] last;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   function automatic logic [5:0] nxt(input logic m,
                                      input logic [5:0] s);
      if (m) return {s[4:0], s[5] ^ s[4]};
      return s + 6'd1;
   endfunction

   task automatic run(input vec_t v);
      int bc = 0;
      int dc = 0;
      int nvec = 0;
      int lidx = -1;
      bit fin = 0;
      logic [5:0] es;
      logic [5:0] ls = '0;
      logic [2:0] esig;
      logic [2:0] fsig;
      for (int i = 0; i < 64; i++) seen[i] = 0;
      es = v.m ? ((v.sd == 6'd0) ? 6'd1 : v.sd) : 6'd0;
`ifdef RESP_MISR_EN
      esig = v.sig_misr;
`else
      esig = v.sig_cap;
`endif
      @(negedge clk);
      mode = v.m; seed = v.sd; vec_count = v.vc;
      resp = v.rsp; start = 1'b1;
      for (int c = 0; c < 1000 && !fin; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) begin
            bc++;
            if (int'(vec_idx) != lidx) begin
               check("run_stim", 32'(stim), 32'(es));
               check("run_idx", 32'(vec_idx), 32'(nvec));
               seen[stim]++;
               ls = stim;
               es = nxt(v.m, es);
               lidx = int'(vec_idx);
               nvec++;
            end
         end
         if (done) begin
            dc++;
            fin = 1;
            check("fin_stim", 32'(stim), 0);
            check("fin_valid", 32'(stim_valid), 0);
            check("fin_idx", 32'(vec_idx), 0);
            check("fin_busy", 32'(busy), 0);
         end
      end
      check("busy_cycles", 32'(bc), 32'(v.cyc));
      check("n_vectors", 32'(nvec), 32'(v.nv));
      check("done_seen", 32'(dc), 1);
      check("last_stim", 32'(ls), 32'(v.last));
      check("signature", 32'(signature), 32'(esig));
      fsig = signature;
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("sig_hold", 32'(signature), 32'(fsig));
   endtask

   initial begin
      logic [2:0] exp_sig;
      int dseen;

      tbl[0] = '{1'b1, 6'd1, 7'd2, 3'b001, 20, 2,
                 3'b011, 3'b001, 6'b000010};
      tbl[1] = '{1'b1, 6'd0, 7'd1, 3'b101, 10, 1,
                 3'b101, 3'b101, 6'b000001};
      tbl[2] = '{1'b0, 6'd9, 7'd5, 3'b000, 640, 64,
                 3'b000, 3'b000, 6'd63};
      tbl[3] = '{1'b1, 6'b100001, 7'd3, 3'b010, 30, 3,
                 3'b101, 3'b010, 6'b000110};
      tbl[4] = '{1'b1, 6'b010000, 7'd2, 3'b111, 20, 2,
                 3'b010, 3'b111, 6'b100001};
      tbl[5] = '{1'b1, 6'd1, 7'd63, 3'b000, 630, 63,
                 3'b000, 3'b000, 6'b100000};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      mode = 1'b0; seed = '0; vec_count = '0; resp = '0;
      #1;
      check("rst_stim", 32'(stim), 0);
      check("rst_valid", 32'(stim_valid), 0);
      check("rst_idx", 32'(vec_idx), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sig", 32'(signature), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) run(tbl[t]);
      check("lfsr_no_zero", 32'(seen[0]), 0);
      for (int i = 1; i < 64; i++)
         check("lfsr_once", 32'(seen[i]), 1);

      // abort at cycle 25 of an exhaustive run
`ifdef RESP_MISR_EN
      exp_sig = 3'b001;
`else
      exp_sig = 3'b110;
`endif
      @(negedge clk);
      mode = 1'b0; resp = 3'b110; start = 1'b1;
      repeat (25) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("ab_pre_stim", 32'(stim), 2);
      check("ab_pre_idx", 32'(vec_idx), 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("ab_stim", 32'(stim), 0);
      check("ab_busy", 32'(busy), 0);
      check("ab_valid", 32'(stim_valid), 0);
      check("ab_sig", 32'(signature), 32'(exp_sig));
      dseen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dseen++;
      end
      check("ab_no_done", 32'(dseen), 0);
      check("ab_sig_hold", 32'(signature), 32'(exp_sig));

      // empty LFSR run clears the signature and pulses done
      mode = 1'b1; seed = 6'd3; vec_count = 7'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("empty_done", 32'(done), 1);
      check("empty_busy", 32'(busy), 0);
      check("empty_sig", 32'(signature), 0);
      check("empty_stim", 32'(stim), 0);
      @(negedge clk);
      check("empty_done_end", 32'(done), 0);

      // start while busy is ignored
      mode = 1'b0; resp = 3'b000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      mode = 1'b1; seed = 6'd5; vec_count = 7'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("sb_stim", 32'(stim), 0);
      check("sb_idx", 32'(vec_idx), 0);
      check("sb_busy", 32'(busy), 1);
      repeat (5) @(negedge clk);
      check("sb_stim_adv", 32'(stim), 1);
      check("sb_idx_adv", 32'(vec_idx), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("sb_abort", 32'(busy), 0);

      // start and abort together in IDLE
      mode = 1'b0; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("sa_busy", 32'(busy), 0);
      check("sa_done", 32'(done), 0);
      check("sa_stim", 32'(stim), 0);

      // asynchronous reset mid-dwell
      mode = 1'b0; resp = 3'b011; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("pr_stim", 32'(stim), 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_stim", 32'(stim), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_valid", 32'(stim_valid), 0);
      check("ar_idx", 32'(vec_idx), 0);
      check("ar_done", 32'(done), 0);
      check("ar_sig", 32'(signature), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rs_stim", 32'(stim), 0);
      check("rs_busy", 32'(busy), 1);
      check("rs_idx", 32'(vec_idx), 0);
      repeat (10) @(negedge clk);
      check("rs_stim_adv", 32'(stim), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
